alien_grid_manager: RTL and testbench

Owns the 50-bit alive mask of the alien formation (`Aliens_Grid`, consumed by the formation mover and renderer). Resolves player-bullet collisions against the formation's current origin (`AliensRow`/`AliensCol` from the mover) and clears the struck alien's bit. It then pulses hit/score outputs to the bullet and score blocks. Sits between the player-bullet block and the formation mover; it is the only writer of the grid.

---
 rtl/alien_grid_manager.sv | 137 +++++++++++++
 tb/tb_alien_grid_manager.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alien_grid_manager.sv
// Alive mask of the 5x10 alien formation; resolves player-bullet hits and clears the struck bit.
// Hit pulses two edges after Bullet_Valid is sampled; holds in WAIT_RELEASE until the bullet is gone.
module alien_grid_manager #(
  parameter int AlienWidth  = 30,
  parameter int AlienHeight = 20,
  parameter int ColPitch    = 40,
  parameter int RowPitch    = 30
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Wave_Start,
  input  logic [8:0]  AliensRow,
  input  logic [9:0]  AliensCol,
  input  logic        Bullet_Valid,
  input  logic [8:0]  BulletRow,
  input  logic [9:0]  BulletCol,
  output logic [49:0] Aliens_Grid,
  output logic        Bullet_Hit,
  output logic        Score_Inc,
  output logic [5:0]  Score_Points,
  output logic [2:0]  Hit_Row,
  output logic [3:0]  Hit_Col,
  output logic        All_Dead
);

  typedef enum logic [1:0] {IDLE, CAPTURE, CHECK, WAIT_RELEASE} state_t;

  localparam logic signed [10:0] ROW_P = 11'(RowPitch);
  localparam logic signed [10:0] COL_P = 11'(ColPitch);
  localparam logic signed [10:0] HGT   = 11'(AlienHeight);
  localparam logic signed [10:0] WID   = 11'(AlienWidth);

  state_t      state;
  logic [8:0]  brow_q, arow_q;
  logic [9:0]  bcol_q, acol_q;
  logic [2:0]  r_q;
  logic [3:0]  c_q;
  logic        hit_q;

  logic signed [10:0] dy, dx, oy, ox;
  logic [2:0]  r_n;
  logic [3:0]  c_n;
  logic        geo_hit;
  logic [5:0]  bit_idx;
  logic [5:0]  points;

  // Repeated subtraction gives quotient and remainder; one extra step lets r/c overflow past the grid.
  always_comb begin
    dy  = $signed({2'b00, brow_q}) - $signed({2'b00, arow_q});
    dx  = $signed({1'b0, bcol_q}) - $signed({1'b0, acol_q});
    oy  = dy;
    ox  = dx;
    r_n = '0;
    c_n = '0;
    for (int k = 0; k < 5; k++) begin
      if (oy >= ROW_P) begin
        oy  = oy - ROW_P;
        r_n = r_n + 3'd1;
      end
    end
    for (int k = 0; k < 10; k++) begin
      if (ox >= COL_P) begin
        ox  = ox - COL_P;
        c_n = c_n + 4'd1;
      end
    end
    geo_hit = !dy[10] && !dx[10] && (r_n <= 3'd4) && (c_n <= 4'd9) &&
              (oy < HGT) && (ox < WID);
  end

  assign bit_idx = 6'(r_q) * 6'd10 + 6'(c_q);
  assign points  = (r_q == 3'd0) ? 6'd30 : (r_q <= 3'd2) ? 6'd20 : 6'd10;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      Aliens_Grid  <= '1;
      Bullet_Hit   <= 1'b0;
      Score_Inc    <= 1'b0;
      Score_Points <= '0;
      Hit_Row      <= '0;
      Hit_Col      <= '0;
      All_Dead     <= 1'b0;
      brow_q       <= '0;
      arow_q       <= '0;
      bcol_q       <= '0;
      acol_q       <= '0;
      r_q          <= '0;
      c_q          <= '0;
      hit_q        <= 1'b0;
    end else begin
      Bullet_Hit <= 1'b0;
      Score_Inc  <= 1'b0;
      All_Dead   <= (Aliens_Grid == '0);
      if (Wave_Start) begin
        Aliens_Grid <= '1;
        state       <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (Bullet_Valid) begin
              brow_q <= BulletRow;
              bcol_q <= BulletCol;
              arow_q <= AliensRow;
              acol_q <= AliensCol;
              state  <= CAPTURE;
            end
          end
          CAPTURE: begin
            r_q   <= r_n;
            c_q   <= c_n;
            hit_q <= geo_hit;
            state <= CHECK;
          end
          CHECK: begin
            if (hit_q && Aliens_Grid[bit_idx]) begin
              Aliens_Grid[bit_idx] <= 1'b0;
              Bullet_Hit           <= 1'b1;
              Score_Inc            <= 1'b1;
              Hit_Row              <= r_q;
              Hit_Col              <= c_q;
              Score_Points         <= points;
              state                <= WAIT_RELEASE;
            end else begin
              state <= IDLE;
            end
          end
          WAIT_RELEASE: begin
            if (!Bullet_Valid) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alien_grid_manager.sv
// Bench for alien_grid_manager: directed table, hand-written corner sequences, random shots vs a model.
module tb_alien_grid_manager;

  logic        Clk = 1'b0;
  logic        Reset, Wave_Start, Bullet_Valid;
  logic [8:0]  AliensRow, BulletRow;
  logic [9:0]  AliensCol, BulletCol;
  logic [49:0] Aliens_Grid;
  logic        Bullet_Hit, Score_Inc, All_Dead;
  logic [5:0]  Score_Points;
  logic [2:0]  Hit_Row;
  logic [3:0]  Hit_Col;

  alien_grid_manager dut (
    .Clk(Clk), .Reset(Reset), .Wave_Start(Wave_Start),
    .AliensRow(AliensRow), .AliensCol(AliensCol),
    .Bullet_Valid(Bullet_Valid), .BulletRow(BulletRow), .BulletCol(BulletCol),
    .Aliens_Grid(Aliens_Grid), .Bullet_Hit(Bullet_Hit), .Score_Inc(Score_Inc),
    .Score_Points(Score_Points), .Hit_Row(Hit_Row), .Hit_Col(Hit_Col),
    .All_Dead(All_Dead)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [49:0] exp_grid;
  int hr, hc, hp;

  typedef struct {
    int arow, acol, brow, bcol;
    bit hit;
    int r, c, pts;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_idx(int arow, int acol, int brow, int bcol);
    int dy, dx;
    dy = brow - arow;
    dx = bcol - acol;
    if (dy < 0 || dx < 0) return -1;
    if (dy / 30 > 4 || dx / 40 > 9) return -1;
    if (dy % 30 >= 20 || dx % 40 >= 30) return -1;
    return (dy / 30) * 10 + dx / 40;
  endfunction

  function automatic int row_points(int r);
    return (r == 0) ? 30 : (r <= 2) ? 20 : 10;
  endfunction

  // One bullet from IDLE: hold Valid through the check, then release it.
  task automatic shot(input int arow, input int acol, input int brow, input int bcol,
                      input bit e_hit, input int e_r, input int e_c, input int e_pts,
                      input logic [49:0] e_grid);
    AliensRow    = 9'(arow);
    AliensCol    = 10'(acol);
    BulletRow    = 9'(brow);
    BulletCol    = 10'(bcol);
    Bullet_Valid = 1'b1;
    @(negedge Clk);
    chk("no_hit_after_e0", 64'(Bullet_Hit), 64'(0));
    @(negedge Clk);
    chk("no_hit_after_e1", 64'(Bullet_Hit), 64'(0));
    @(negedge Clk);
    chk("bullet_hit", 64'(Bullet_Hit), 64'(e_hit));
    chk("score_inc", 64'(Score_Inc), 64'(e_hit));
    chk("grid", 64'(Aliens_Grid), 64'(e_grid));
    chk("hit_row", 64'(Hit_Row), 64'(e_r));
    chk("hit_col", 64'(Hit_Col), 64'(e_c));
    chk("score_points", 64'(Score_Points), 64'(e_pts));
    Bullet_Valid = 1'b0;
    @(negedge Clk);
    chk("pulse_one_cycle", 64'(Bullet_Hit), 64'(0));
    chk("all_dead", 64'(All_Dead), 64'(e_grid == '0));
  endtask

  initial begin
    int idx, arow, acol, brow, bcol, hits, hit_at;
    bit seen, e_hit;

    tbl[0]  = '{0,   10,  5,   15,  1'b1, 0, 0, 30};
    tbl[1]  = '{0,   10,  5,   15,  1'b0, 0, 0, 30};
    tbl[2]  = '{0,   10,  125, 375, 1'b1, 4, 9, 10};
    tbl[3]  = '{0,   10,  25,  15,  1'b0, 4, 9, 10};
    tbl[4]  = '{0,   10,  5,   42,  1'b0, 4, 9, 10};
    tbl[5]  = '{0,   10,  5,   5,   1'b0, 4, 9, 10};
    tbl[6]  = '{0,   10,  5,   410, 1'b0, 4, 9, 10};
    tbl[7]  = '{100, 200, 135, 245, 1'b1, 1, 1, 20};
    tbl[8]  = '{50,  0,   129, 109, 1'b1, 2, 2, 20};
    tbl[9]  = '{50,  0,   160, 0,   1'b0, 2, 2, 20};
    tbl[10] = '{0,   0,   95,  360, 1'b1, 3, 9, 10};
    tbl[11] = '{0,   0,   150, 0,   1'b0, 3, 9, 10};

    Reset = 1'b1; Wave_Start = 1'b0; Bullet_Valid = 1'b0;
    AliensRow = '0; AliensCol = '0; BulletRow = '0; BulletCol = '0;
    exp_grid = '1;
    @(negedge Clk); @(negedge Clk);
    chk("rst_grid", 64'(Aliens_Grid), 64'(exp_grid));
    chk("rst_hit", 64'(Bullet_Hit), 64'(0));
    chk("rst_score_inc", 64'(Score_Inc), 64'(0));
    chk("rst_all_dead", 64'(All_Dead), 64'(0));
    chk("rst_points", 64'(Score_Points), 64'(0));
    chk("rst_hit_rc", 64'({Hit_Row, Hit_Col}), 64'(0));
    Reset = 1'b0;
    @(negedge Clk);

    foreach (tbl[i]) begin
      if (tbl[i].hit) exp_grid[tbl[i].r * 10 + tbl[i].c] = 1'b0;
      shot(tbl[i].arow, tbl[i].acol, tbl[i].brow, tbl[i].bcol,
           tbl[i].hit, tbl[i].r, tbl[i].c, tbl[i].pts, exp_grid);
    end
    hr = 3; hc = 9; hp = 10;

    // Bullet parked in the row gap keeps re-checking, then moves onto a live alien.
    AliensRow = 9'd0; AliensCol = 10'd10; BulletRow = 9'd25; BulletCol = 10'd15;
    Bullet_Valid = 1'b1;
    seen = 1'b0;
    repeat (9) begin
      @(negedge Clk);
      if (Bullet_Hit) seen = 1'b1;
    end
    chk("gap_no_hit", 64'(seen), 64'(0));
    BulletRow = 9'd35; BulletCol = 10'd95;
    hits = 0; hit_at = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk);
      if (Bullet_Hit) begin
        hits++;
        if (hit_at < 0) hit_at = k;
      end
    end
    chk("recheck_found_hit", 64'(hit_at >= 0 && hit_at <= 5), 64'(1));
    chk("one_hit_per_bullet", 64'(hits), 64'(1));
    exp_grid[12] = 1'b0; hr = 1; hc = 2; hp = 20;
    chk("recheck_grid", 64'(Aliens_Grid), 64'(exp_grid));
    chk("recheck_rc", 64'({Hit_Row, Hit_Col}), 64'({3'(hr), 4'(hc)}));
    Bullet_Valid = 1'b0;
    @(negedge Clk); @(negedge Clk);

    for (int n = 0; n < 60; n++) begin
      arow = int'($urandom_range(0, 300));
      acol = int'($urandom_range(0, 500));
      brow = arow + int'($urandom_range(0, 5)) * 30 + int'($urandom_range(0, 29));
      bcol = acol + int'($urandom_range(0, 10)) * 40 + int'($urandom_range(0, 39));
      if ($urandom_range(0, 7) == 0 && arow >= 20) brow = arow - int'($urandom_range(1, 20));
      if ($urandom_range(0, 7) == 0 && acol >= 20) bcol = acol - int'($urandom_range(1, 20));
      idx = model_idx(arow, acol, brow, bcol);
      e_hit = (idx >= 0) && exp_grid[idx];
      if (e_hit) begin
        exp_grid[idx] = 1'b0;
        hr = idx / 10; hc = idx % 10; hp = row_points(hr);
      end
      shot(arow, acol, brow, bcol, e_hit, hr, hc, hp, exp_grid);
    end

    Wave_Start = 1'b1;
    @(negedge Clk);
    Wave_Start = 1'b0;
    exp_grid = '1;
    chk("wave_reload", 64'(Aliens_Grid), 64'(exp_grid));

    // Wave_Start landing on the CHECK edge of a real hit wins.
    AliensRow = 9'd0; AliensCol = 10'd10; BulletRow = 9'd5; BulletCol = 10'd15;
    Bullet_Valid = 1'b1;
    @(negedge Clk); @(negedge Clk);
    Wave_Start = 1'b1;
    @(negedge Clk);
    chk("wave_vs_hit_pulse", 64'(Bullet_Hit), 64'(0));
    chk("wave_vs_hit_grid", 64'(Aliens_Grid), 64'(exp_grid));
    chk("wave_vs_hit_held", 64'({Hit_Row, Hit_Col, Score_Points}), 64'({3'(hr), 4'(hc), 6'(hp)}));
    Wave_Start = 1'b0; Bullet_Valid = 1'b0;
    @(negedge Clk); @(negedge Clk);

    for (int i = 0; i < 50; i++) begin
      exp_grid[i] = 1'b0;
      hr = i / 10; hc = i % 10; hp = row_points(hr);
      shot(0, 0, hr * 30 + 5, hc * 40 + 5, 1'b1, hr, hc, hp, exp_grid);
    end
    Wave_Start = 1'b1;
    @(negedge Clk);
    Wave_Start = 1'b0;
    exp_grid = '1;
    chk("wave_after_clear_grid", 64'(Aliens_Grid), 64'(exp_grid));
    @(negedge Clk);
    chk("wave_all_dead_low", 64'(All_Dead), 64'(0));

    // Reset while the hit pulse is high and the FSM sits in WAIT_RELEASE.
    AliensRow = 9'd0; AliensCol = 10'd10; BulletRow = 9'd125; BulletCol = 10'd375;
    Bullet_Valid = 1'b1;
    repeat (3) @(negedge Clk);
    chk("pre_reset_hit", 64'(Bullet_Hit), 64'(1));
    Reset = 1'b1;
    #1;
    chk("async_rst_pulse_cut", 64'({Bullet_Hit, Score_Inc}), 64'(0));
    chk("async_rst_grid", 64'(Aliens_Grid), 64'(exp_grid));
    chk("async_rst_held", 64'({Hit_Row, Hit_Col, Score_Points}), 64'(0));
    @(negedge Clk);
    Reset = 1'b0; Bullet_Valid = 1'b0;
    @(negedge Clk);
    exp_grid[0] = 1'b0;
    shot(0, 10, 5, 15, 1'b1, 0, 0, 30, exp_grid);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
